// File: rtl/hazard_sequencer.sv
// Hazard controller around the decode stage and the ID/EX register.
// Detects load-use hazards, sequences multi-cycle MUL/DIV/MOD ops with a
// latency down-counter, flushes wrong-path work on a taken branch, and
// keeps saturating stall/flush event counters for performance debug.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal flow; branch flush, multi-cycle start, load-use bubble
// MC_BUSY | multi-cycle op holding EX; cnt counts remaining stall cycles
module hazard_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ifid_valid,
  input  logic [3:0]       rn_ifid,
  input  logic [3:0]       rm_ifid,
  input  logic             ifid_uses_rn,
  input  logic             ifid_uses_rm,
  input  logic             idex_valid,
  input  logic             idex_mem_read,
  input  logic [3:0]       idex_rd,
  input  logic [3:0]       idex_alu_op,
  input  logic             branch_taken_ex,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             id_ex_nop,
  output logic             idex_stall,
  output logic             exmem_nop,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int CW = $clog2(DIV_LAT);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MC_BUSY = 1'b1;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic mc_start, is_mul, lu_hazard;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, id_ex_nop_c;
  logic idex_stall_c, exmem_nop_c, mc_done_c;

  // Hazard and multi-cycle-op detection on the current pipeline contents.
  always_comb begin
    is_mul    = (idex_alu_op == OP_MUL);
    mc_start  = idex_valid & (is_mul | (idex_alu_op == OP_DIV) | (idex_alu_op == OP_MOD));
    lu_hazard = idex_valid & idex_mem_read & ifid_valid &
                ((ifid_uses_rn & (rn_ifid == idex_rd)) |
                 (ifid_uses_rm & (rm_ifid == idex_rd)));
  end

  // Next-state, counter and raw control decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    id_ex_nop_c  = 1'b0;
    idex_stall_c = 1'b0;
    exmem_nop_c  = 1'b0;
    mc_done_c    = 1'b0;
    if (state == RUN) begin
      if (branch_taken_ex) begin
        // Any IF/ID consumer is wrong-path, so a load-use match is moot.
        ifid_flush_c = 1'b1;
        id_ex_nop_c  = 1'b1;
      end else if (mc_start) begin
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        idex_stall_c = 1'b1;
        exmem_nop_c  = 1'b1;
        cnt_nxt      = is_mul ? MUL_LOAD : DIV_LOAD;
        state_nxt    = MC_BUSY;
      end else if (lu_hazard) begin
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        id_ex_nop_c  = 1'b1;
      end
    end else begin
      if (cnt != '0) begin
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        idex_stall_c = 1'b1;
        exmem_nop_c  = 1'b1;
        cnt_nxt      = cnt - CW'(1);
      end else begin
        mc_done_c = 1'b1;
        state_nxt = RUN;
      end
    end
  end

  // Outputs are forced low for the whole time reset is asserted.
  always_comb begin
    pc_stall   = reset_n & pc_stall_c;
    ifid_stall = reset_n & ifid_stall_c;
    ifid_flush = reset_n & ifid_flush_c;
    id_ex_nop  = reset_n & id_ex_nop_c;
    idex_stall = reset_n & idex_stall_c;
    exmem_nop  = reset_n & exmem_nop_c;
    mc_busy    = reset_n & (state == MC_BUSY);
    mc_done    = reset_n & mc_done_c;
  end

  // FSM state and latency down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating event counters for stalls and flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (ifid_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: load-use, MUL, DIV/MOD back-to-back,
// branch flush, mid-op reset and counter saturation (CNT_W=4 instance).
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ifid_valid, ifid_uses_rn, ifid_uses_rm;
  logic [3:0] rn_ifid, rm_ifid;
  logic       idex_valid, idex_mem_read;
  logic [3:0] idex_rd, idex_alu_op;
  logic       branch_taken_ex;

  logic        pc_stall, ifid_stall, ifid_flush, id_ex_nop;
  logic        idex_stall, exmem_nop, mc_busy, mc_done;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_id_ex_nop;
  logic        s_idex_stall, s_exmem_nop, s_mc_busy, s_mc_done;
  logic [3:0]  s_stall_count, s_flush_count;

  int total = 0;
  int bad   = 0;

  // Control bits: pc_stall ifid_stall ifid_flush id_ex_nop idex_stall exmem_nop mc_busy mc_done
  logic [7:0] ctl;
  assign ctl = {pc_stall, ifid_stall, ifid_flush, id_ex_nop,
                idex_stall, exmem_nop, mc_busy, mc_done};

  localparam logic [7:0] C_IDLE  = 8'h00;
  localparam logic [7:0] C_LU    = 8'hD0;
  localparam logic [7:0] C_MCST  = 8'hCC;
  localparam logic [7:0] C_MCBSY = 8'hCE;
  localparam logic [7:0] C_MCEND = 8'h03;
  localparam logic [7:0] C_BR    = 8'h30;

  always #5 clk = ~clk;

  hazard_sequencer #(.MUL_LAT(4), .DIV_LAT(16), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifid_valid(ifid_valid), .rn_ifid(rn_ifid), .rm_ifid(rm_ifid),
    .ifid_uses_rn(ifid_uses_rn), .ifid_uses_rm(ifid_uses_rm),
    .idex_valid(idex_valid), .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd), .idex_alu_op(idex_alu_op),
    .branch_taken_ex(branch_taken_ex),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .id_ex_nop(id_ex_nop), .idex_stall(idex_stall), .exmem_nop(exmem_nop),
    .mc_busy(mc_busy), .mc_done(mc_done),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_sequencer #(.MUL_LAT(4), .DIV_LAT(16), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .ifid_valid(ifid_valid), .rn_ifid(rn_ifid), .rm_ifid(rm_ifid),
    .ifid_uses_rn(ifid_uses_rn), .ifid_uses_rm(ifid_uses_rm),
    .idex_valid(idex_valid), .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd), .idex_alu_op(idex_alu_op),
    .branch_taken_ex(branch_taken_ex),
    .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush),
    .id_ex_nop(s_id_ex_nop), .idex_stall(s_idex_stall), .exmem_nop(s_exmem_nop),
    .mc_busy(s_mc_busy), .mc_done(s_mc_done),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    ifid_valid = 1'b0; rn_ifid = 4'd0; rm_ifid = 4'd0;
    ifid_uses_rn = 1'b0; ifid_uses_rm = 1'b0;
    idex_valid = 1'b0; idex_mem_read = 1'b0; idex_rd = 4'd0;
    idex_alu_op = 4'd0; branch_taken_ex = 1'b0;
  endtask

  task automatic load_use_r3;
    ifid_valid = 1'b1; rn_ifid = 4'd3; rm_ifid = 4'd7;
    ifid_uses_rn = 1'b1; ifid_uses_rm = 1'b0;
    idex_valid = 1'b1; idex_mem_read = 1'b1; idex_rd = 4'd3;
    idex_alu_op = 4'b0000; branch_taken_ex = 1'b0;
  endtask

  initial begin
    // Reset held with hazard-rich inputs: every output must stay low.
    reset_n = 1'b0;
    load_use_r3();
    branch_taken_ex = 1'b1;
    smp();
    chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("reset_stall_cnt", 32'(stall_count), 0);
    chk("reset_flush_cnt", 32'(flush_count), 0);
    nxt();
    idle_inputs();
    reset_n = 1'b1;
    smp();
    chk("post_reset_idle", 32'(ctl), 32'(C_IDLE));

    // Load-use on Rn: exactly one bubble cycle.
    nxt();
    load_use_r3();
    smp();
    chk("lu_rn_stall", 32'(ctl), 32'(C_LU));
    nxt();
    idex_valid = 1'b0; idex_mem_read = 1'b0;
    smp();
    chk("lu_release", 32'(ctl), 32'(C_IDLE));
    chk("lu_stall_cnt", 32'(stall_count), 1);

    // Same stimulus, Rn not read: no stall.
    nxt();
    load_use_r3();
    ifid_uses_rn = 1'b0;
    smp();
    chk("lu_no_use", 32'(ctl), 32'(C_IDLE));

    // Load-use through Rm.
    nxt();
    load_use_r3();
    ifid_uses_rn = 1'b0; ifid_uses_rm = 1'b1; rm_ifid = 4'd3;
    smp();
    chk("lu_rm_stall", 32'(ctl), 32'(C_LU));

    // Register mismatch: no stall.
    nxt();
    load_use_r3();
    idex_rd = 4'd5;
    smp();
    chk("lu_rd_mismatch", 32'(ctl), 32'(C_IDLE));
    nxt();
    idle_inputs();
    smp();
    chk("lu2_stall_cnt", 32'(stall_count), 2);

    // MUL, latency 4: 3 stall cycles then mc_done; a branch mid-op is ignored.
    nxt();
    idex_valid = 1'b1; idex_alu_op = 4'b0010;
    smp();
    chk("mul_c1", 32'(ctl), 32'(C_MCST));
    nxt();
    branch_taken_ex = 1'b1;
    smp();
    chk("mul_c2_branch_ignored", 32'(ctl), 32'(C_MCBSY));
    nxt();
    branch_taken_ex = 1'b0;
    smp();
    chk("mul_c3", 32'(ctl), 32'(C_MCBSY));
    nxt();
    smp();
    chk("mul_c4_done", 32'(ctl), 32'(C_MCEND));
    nxt();
    idle_inputs();
    smp();
    chk("mul_after", 32'(ctl), 32'(C_IDLE));
    chk("mul_stall_cnt", 32'(stall_count), 5);
    chk("mul_flush_cnt", 32'(flush_count), 0);

    // DIV then MOD back-to-back, latency 16 each.
    nxt();
    idex_valid = 1'b1; idex_alu_op = 4'b0011;
    smp();
    chk("div_c1", 32'(ctl), 32'(C_MCST));
    for (int i = 0; i < 14; i++) begin
      nxt();
      smp();
      chk($sformatf("div_busy%0d", i), 32'(ctl), 32'(C_MCBSY));
    end
    nxt();
    smp();
    chk("div_done", 32'(ctl), 32'(C_MCEND));
    chk("div_stall_cnt", 32'(stall_count), 20);
    nxt();
    idex_alu_op = 4'b0100;
    smp();
    chk("mod_c1", 32'(ctl), 32'(C_MCST));
    for (int i = 0; i < 14; i++) begin
      nxt();
      smp();
      chk($sformatf("mod_busy%0d", i), 32'(ctl), 32'(C_MCBSY));
    end
    nxt();
    smp();
    chk("mod_done", 32'(ctl), 32'(C_MCEND));
    nxt();
    idle_inputs();
    smp();
    chk("divmod_stall_cnt", 32'(stall_count), 35);

    // Taken branch with a simultaneous load-use hazard: flush only.
    nxt();
    load_use_r3();
    branch_taken_ex = 1'b1;
    smp();
    chk("branch_flush", 32'(ctl), 32'(C_BR));
    nxt();
    idle_inputs();
    smp();
    chk("branch_flush_cnt", 32'(flush_count), 1);
    chk("branch_stall_cnt", 32'(stall_count), 35);

    // Reset during the 5th cycle of a DIV.
    nxt();
    idex_valid = 1'b1; idex_alu_op = 4'b0011;
    smp();
    chk("rdiv_c1", 32'(ctl), 32'(C_MCST));
    for (int i = 0; i < 3; i++) begin
      nxt();
      smp();
    end
    chk("rdiv_c4", 32'(ctl), 32'(C_MCBSY));
    nxt();
    chk("rdiv_c5_stall_cnt", 32'(stall_count), 39);
    reset_n = 1'b0;
    #1;
    chk("rdiv_reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rdiv_reset_stall_cnt", 32'(stall_count), 0);
    chk("rdiv_reset_flush_cnt", 32'(flush_count), 0);
    nxt();
    idle_inputs();
    reset_n = 1'b1;
    smp();
    chk("rdiv_release", 32'(ctl), 32'(C_IDLE));
    nxt();
    smp();
    chk("rdiv_release2", 32'(ctl), 32'(C_IDLE));

    // 20 consecutive load-use stall cycles: CNT_W=4 instance saturates at 15.
    nxt();
    load_use_r3();
    for (int i = 0; i < 20; i++) begin
      smp();
      if (i == 0) chk("sat_lu_stall", 32'(s_pc_stall), 1);
      nxt();
    end
    idle_inputs();
    smp();
    chk("sat_stall_cnt", 32'(s_stall_count), 15);
    chk("wide_stall_cnt", 32'(stall_count), 20);
    nxt();
    smp();
    chk("sat_stall_hold", 32'(s_stall_count), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
